alu_ctrl: RTL



---
 rtl/alu_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// Sequencing controller for the calculator datapath: button edges drive operand
// loads and walk the ALU opcode through add, subtract and modulo.
//
// state | meaning
// S_A   | waiting to latch operand A
// S_B   | waiting to latch operand B
// S_ADD | ALU performs add
// S_SUB | ALU performs subtract
// S_MOD | ALU performs modulo; next enter wraps to S_ADD
module alu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic       sign,
    input  logic       clear,
    output logic [1:0] reg_ctrl,
    output logic [3:0] fn,
    output logic       signed_mode
);

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_ADD = 3'd2,
        S_SUB = 3'd3,
        S_MOD = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   mode_nxt;
    logic   enter_d;
    logic   sign_d;
    logic   clear_d;
    logic   enter_ev;
    logic   sign_ev;
    logic   clear_ev;

    assign enter_ev = enter & ~enter_d;
    assign sign_ev  = sign  & ~sign_d;
    assign clear_ev = clear & ~clear_d;

    function automatic logic [3:0] fn_enc(input state_t s, input logic m);
        case (s)
            S_A:     return 4'b0000;
            S_B:     return 4'b0001;
            S_ADD:   return {m, 3'd2};
            S_SUB:   return {m, 3'd3};
            S_MOD:   return {m, 3'd4};
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        mode_nxt  = signed_mode ^ sign_ev;
        if (enter_ev) begin
            case (state)
                S_A:     state_nxt = S_B;
                S_B:     state_nxt = S_ADD;
                S_ADD:   state_nxt = S_SUB;
                S_SUB:   state_nxt = S_MOD;
                S_MOD:   state_nxt = S_ADD;
                default: state_nxt = S_A;
            endcase
        end
    end

    // Edge-detect flops reset high so a button held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_A;
            fn          <= 4'b0000;
            reg_ctrl    <= 2'b00;
            signed_mode <= 1'b0;
            enter_d     <= 1'b1;
            sign_d      <= 1'b1;
            clear_d     <= 1'b1;
        end else begin
            enter_d <= enter;
            sign_d  <= sign;
            clear_d <= clear;
            if (clear_ev) begin
                state       <= S_A;
                fn          <= 4'b0000;
                reg_ctrl    <= 2'b00;
                signed_mode <= 1'b0;
            end else begin
                state       <= state_nxt;
                signed_mode <= mode_nxt;
                fn          <= fn_enc(state_nxt, mode_nxt);
                if (enter_ev && state == S_A)
                    reg_ctrl <= 2'b01;
                else if (enter_ev && state == S_B)
                    reg_ctrl <= 2'b10;
                else
                    reg_ctrl <= 2'b00;
            end
        end
    end

endmodule
